// File: rtl/mem_wb_pipe_if.sv
// MEM->WB stage bundle: M-side capture fields, W-side write-back outputs and stage controls.
// Latency: none (wires only); the pipe register lives in mem_wb_pipe.
// Backpressure: StallW holds the W stage, FlushW injects a bubble; no ready path upstream.
interface mem_wb_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PC_W       = 32,
    parameter int CNT_W      = 32
);
    // stage controls
    logic                  StallW;
    logic                  FlushW;
    // M-stage fields
    logic                  ValidM;
    logic                  RegWriteM;
    logic                  MemtoRegM;
    logic                  LinkM;
    logic [1:0]            LoadSizeM;
    logic                  LoadSignedM;
    logic [DATA_W-1:0]     ALUOutM;
    logic [DATA_W-1:0]     ReadDataM;
    logic [PC_W-1:0]       PCplus4M;
    logic [REG_ADDR_W-1:0] WriteRegM;
    // W-stage results
    logic                  ValidW;
    logic                  RegWriteW;
    logic [REG_ADDR_W-1:0] WriteRegW;
    logic [DATA_W-1:0]     ResultW;
    logic [CNT_W-1:0]      RetireCountW;

    // upstream pipeline / hazard unit side
    modport master (
        output StallW, FlushW, ValidM, RegWriteM, MemtoRegM, LinkM, LoadSizeM,
               LoadSignedM, ALUOutM, ReadDataM, PCplus4M, WriteRegM,
        input  ValidW, RegWriteW, WriteRegW, ResultW, RetireCountW
    );

    // pipe register side
    modport slave (
        input  StallW, FlushW, ValidM, RegWriteM, MemtoRegM, LinkM, LoadSizeM,
               LoadSignedM, ALUOutM, ReadDataM, PCplus4M, WriteRegM,
        output ValidW, RegWriteW, WriteRegW, ResultW, RetireCountW
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with load extraction, result select and retire counter.
// Latency: 1 cycle M->W; ResultW/RegWriteW are combinational from W registers.
// Backpressure: StallW holds every W register and the counter; FlushW (wins) loads a bubble.
module mem_wb_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int PC_W       = 32,
    parameter int CNT_W      = 32
) (
    input  logic          CLOCK,
    input  logic          RESET_N,
    mem_wb_pipe_if.slave  bus
);

    // byte-offset width within a datapath word: 2 for 32-bit, 3 for 64-bit
    localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

    localparam logic [1:0] SZ_WORD  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_BYTE  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    logic                  valid_q,    valid_d;
    logic                  regwrite_q, regwrite_d;
    logic                  memtoreg_q, memtoreg_d;
    logic                  link_q,     link_d;
    logic [1:0]            lsize_q,    lsize_d;
    logic                  lsigned_q,  lsigned_d;
    logic [DATA_W-1:0]     aluout_q,   aluout_d;
    logic [DATA_W-1:0]     rdata_q,    rdata_d;
    logic [PC_W-1:0]       pc4_q,      pc4_d;
    logic [REG_ADDR_W-1:0] wreg_q,     wreg_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;

    logic [OFF_W-1:0]      offset;
    logic [DATA_W-1:0]     sh_b;
    logic [DATA_W-1:0]     sh_h;
    logic [DATA_W-1:0]     sh_w;
    logic [DATA_W-1:0]     ext_b;
    logic [DATA_W-1:0]     ext_h;
    logic [DATA_W-1:0]     ext_w;
    logic [DATA_W-1:0]     load_data;
    logic [DATA_W-1:0]     result;

    // next-state select: flush beats stall, stall holds, otherwise capture M
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        link_d     = link_q;
        lsize_d    = lsize_q;
        lsigned_d  = lsigned_q;
        aluout_d   = aluout_q;
        rdata_d    = rdata_q;
        pc4_d      = pc4_q;
        wreg_d     = wreg_q;
        cnt_d      = cnt_q;
        if (bus.FlushW) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            link_d     = 1'b0;
            lsize_d    = '0;
            lsigned_d  = 1'b0;
            aluout_d   = '0;
            rdata_d    = '0;
            pc4_d      = '0;
            wreg_d     = '0;
        end else if (!bus.StallW) begin
            valid_d    = bus.ValidM;
            regwrite_d = bus.RegWriteM;
            memtoreg_d = bus.MemtoRegM;
            link_d     = bus.LinkM;
            lsize_d    = bus.LoadSizeM;
            lsigned_d  = bus.LoadSignedM;
            aluout_d   = bus.ALUOutM;
            rdata_d    = bus.ReadDataM;
            pc4_d      = bus.PCplus4M;
            wreg_d     = bus.WriteRegM;
            if (bus.ValidM) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // W-stage registers with synchronous active-low reset
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            link_q     <= 1'b0;
            lsize_q    <= '0;
            lsigned_q  <= 1'b0;
            aluout_q   <= '0;
            rdata_q    <= '0;
            pc4_q      <= '0;
            wreg_q     <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            link_q     <= link_d;
            lsize_q    <= lsize_d;
            lsigned_q  <= lsigned_d;
            aluout_q   <= aluout_d;
            rdata_q    <= rdata_d;
            pc4_q      <= pc4_d;
            wreg_q     <= wreg_d;
            cnt_q      <= cnt_d;
        end
    end

    // lane extraction: shift the addressed lane down, then extend via an upper-bit mask
    always_comb begin
        offset = aluout_q[OFF_W-1:0];
        sh_b   = rdata_q >> {offset, 3'b000};
        // misaligned halves round down to the even byte
        sh_h   = rdata_q >> {offset[OFF_W-1:1], 4'b0000};
        // on a 64-bit path offset[2] picks the upper word; a 32-bit path has one word
        if (DATA_W == 64) begin
            sh_w = rdata_q >> {offset[OFF_W-1], 5'b00000};
        end else begin
            sh_w = rdata_q;
        end
        ext_b = DATA_W'(sh_b[7:0]);
        if (lsigned_q && sh_b[7]) begin
            ext_b = ext_b | ~DATA_W'(8'hFF);
        end
        ext_h = DATA_W'(sh_h[15:0]);
        if (lsigned_q && sh_h[15]) begin
            ext_h = ext_h | ~DATA_W'(16'hFFFF);
        end
        // on a 32-bit path the mask is all-zero, so a word load is never extended
        ext_w = DATA_W'(sh_w[31:0]);
        if (lsigned_q && sh_w[31]) begin
            ext_w = ext_w | ~DATA_W'(32'hFFFF_FFFF);
        end
        case (lsize_q)
            SZ_BYTE:  load_data = ext_b;
            SZ_HALF:  load_data = ext_h;
            SZ_WORD:  load_data = ext_w;
            SZ_DWORD: load_data = (DATA_W == 64) ? rdata_q : ext_w;
            default:  load_data = ext_w;
        endcase
    end

    // result select from W registers only: link beats load beats ALU; bubbles read as zero
    always_comb begin
        if (!valid_q) begin
            result = '0;
        end else if (link_q) begin
            result = DATA_W'(pc4_q);
        end else if (memtoreg_q) begin
            result = load_data;
        end else begin
            result = aluout_q;
        end
    end

    assign bus.ValidW       = valid_q;
    assign bus.RegWriteW    = regwrite_q & valid_q & (wreg_q != '0);
    assign bus.WriteRegW    = wreg_q;
    assign bus.ResultW      = result;
    assign bus.RetireCountW = cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: a 32-bit/32-bit-counter instance and a 64-bit/4-bit-counter instance.
// Stimulus pushes the hand-computed W-stage response per edge; a monitor pops and compares after each edge.
// Every queued entry must be consumed exactly at its target edge.
module tb_mem_wb_pipe;

    logic clk;
    logic rst32_n;
    logic rst64_n;

    mem_wb_pipe_if #(.DATA_W(32), .REG_ADDR_W(5), .PC_W(32), .CNT_W(32)) if32 ();
    mem_wb_pipe_if #(.DATA_W(64), .REG_ADDR_W(5), .PC_W(32), .CNT_W(4))  if64 ();

    mem_wb_pipe #(.DATA_W(32), .REG_ADDR_W(5), .PC_W(32), .CNT_W(32)) u_dut32 (
        .CLOCK   (clk),
        .RESET_N (rst32_n),
        .bus     (if32)
    );

    mem_wb_pipe #(.DATA_W(64), .REG_ADDR_W(5), .PC_W(32), .CNT_W(4)) u_dut64 (
        .CLOCK   (clk),
        .RESET_N (rst64_n),
        .bus     (if64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        sel;
        logic [31:0] tgt;
        logic        vld;
        logic        rw;
        logic [4:0]  wr;
        logic [63:0] res;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] edge_cnt = 0;
    logic [31:0] ecnt [2];
    logic [4:0]  ewr  [2];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_cnt);
        end
    endtask

    // monitor: after each edge, consume the entry aimed at that edge
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb_q.size() > 0 && sb_q[0].tgt <= edge_cnt) begin
            e = sb_q.pop_front();
            if (e.tgt != edge_cnt) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stale_entry: got edge %0d expected edge %0d", edge_cnt, e.tgt);
            end else if (e.sel == 1'b0) begin
                chk("dut32.ValidW",       {63'd0, if32.ValidW},       {63'd0, e.vld});
                chk("dut32.RegWriteW",    {63'd0, if32.RegWriteW},    {63'd0, e.rw});
                chk("dut32.WriteRegW",    {59'd0, if32.WriteRegW},    {59'd0, e.wr});
                chk("dut32.ResultW",      {32'd0, if32.ResultW},      e.res);
                chk("dut32.RetireCountW", {32'd0, if32.RetireCountW}, {32'd0, e.cnt});
            end else begin
                chk("dut64.ValidW",       {63'd0, if64.ValidW},       {63'd0, e.vld});
                chk("dut64.RegWriteW",    {63'd0, if64.RegWriteW},    {63'd0, e.rw});
                chk("dut64.WriteRegW",    {59'd0, if64.WriteRegW},    {59'd0, e.wr});
                chk("dut64.ResultW",      if64.ResultW,               e.res);
                chk("dut64.RetireCountW", {60'd0, if64.RetireCountW}, {32'd0, e.cnt});
            end
        end
    end

    // drive one M-stage vector into the selected instance, queue its W response, step one edge
    task automatic apply(
        input logic        sel,
        input logic        rn, st, fl,
        input logic        v, rw, m2r, lk,
        input logic [1:0]  ls,
        input logic        sg,
        input logic [63:0] alu, rd,
        input logic [31:0] pc,
        input logic [4:0]  wr,
        input logic        e_v, e_rw,
        input logic [63:0] e_res
    );
        exp_t e;
        if (sel == 1'b0) begin
            rst32_n = rn; if32.StallW = st; if32.FlushW = fl;
            if32.ValidM = v; if32.RegWriteM = rw; if32.MemtoRegM = m2r; if32.LinkM = lk;
            if32.LoadSizeM = ls; if32.LoadSignedM = sg;
            if32.ALUOutM = alu[31:0]; if32.ReadDataM = rd[31:0];
            if32.PCplus4M = pc; if32.WriteRegM = wr;
        end else begin
            rst64_n = rn; if64.StallW = st; if64.FlushW = fl;
            if64.ValidM = v; if64.RegWriteM = rw; if64.MemtoRegM = m2r; if64.LinkM = lk;
            if64.LoadSizeM = ls; if64.LoadSignedM = sg;
            if64.ALUOutM = alu; if64.ReadDataM = rd;
            if64.PCplus4M = pc; if64.WriteRegM = wr;
        end
        if (!rn) ecnt[sel] = 0;
        else if (!fl && !st && v) ecnt[sel] = ecnt[sel] + 1;
        if (sel) ecnt[sel] = ecnt[sel] & 32'hF;
        if (!rn || fl) ewr[sel] = 5'd0;
        else if (!st) ewr[sel] = wr;
        e.sel = sel; e.tgt = edge_cnt + 1;
        e.vld = e_v; e.rw = e_rw; e.wr = ewr[sel]; e.res = e_res; e.cnt = ecnt[sel];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] RD32 = 64'h0000_0000_8899_AABB;
    localparam logic [63:0] RD64 = 64'hF0E0_D0C0_B0A0_9080;
    localparam logic [31:0] PC0  = 32'h0040_0008;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ecnt[0] = 0; ecnt[1] = 0; ewr[0] = 0; ewr[1] = 0;
        rst32_n = 1'b0; rst64_n = 1'b0;
        if32.StallW = 0; if32.FlushW = 0; if32.ValidM = 0; if32.RegWriteM = 0;
        if32.MemtoRegM = 0; if32.LinkM = 0; if32.LoadSizeM = 0; if32.LoadSignedM = 0;
        if32.ALUOutM = 0; if32.ReadDataM = 0; if32.PCplus4M = 0; if32.WriteRegM = 0;
        if64.StallW = 0; if64.FlushW = 0; if64.ValidM = 0; if64.RegWriteM = 0;
        if64.MemtoRegM = 0; if64.LinkM = 0; if64.LoadSizeM = 0; if64.LoadSignedM = 0;
        if64.ALUOutM = 0; if64.ReadDataM = 0; if64.PCplus4M = 0; if64.WriteRegM = 0;

        //      sel rn st fl  v rw m2 lk  ls    sg  alu      rd    pc   wr   ev erw res
        // reset state
        apply(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 64'h0,   64'h0, 0,   5'd0, 0, 0, 64'h0);
        // three ALU instructions, then reset mid-stream with stall asserted
        apply(0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 64'h11,  64'h0, 0,   5'd1, 1, 1, 64'h11);
        apply(0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 64'h22,  64'h0, 0,   5'd2, 1, 1, 64'h22);
        apply(0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 64'h33,  64'h0, 0,   5'd3, 1, 1, 64'h33);
        apply(0, 0, 1, 0, 1, 1, 0, 0, 2'b00, 0, 64'h44,  64'h0, 0,   5'd4, 0, 0, 64'h0);
        // load extraction, 32-bit path
        apply(0, 1, 0, 0, 1, 1, 1, 0, 2'b10, 1, 64'h100, RD32, 0,   5'd5, 1, 1, 64'hFFFF_FFBB);
        apply(0, 1, 0, 0, 1, 1, 1, 0, 2'b10, 0, 64'h102, RD32, 0,   5'd5, 1, 1, 64'h0000_0099);
        apply(0, 1, 0, 0, 1, 1, 1, 0, 2'b01, 1, 64'h103, RD32, 0,   5'd5, 1, 1, 64'hFFFF_8899);
        apply(0, 1, 0, 0, 1, 1, 1, 0, 2'b01, 0, 64'h100, RD32, 0,   5'd5, 1, 1, 64'h0000_AABB);
        apply(0, 1, 0, 0, 1, 1, 1, 0, 2'b11, 1, 64'h100, RD32, 0,   5'd5, 1, 1, 64'h8899_AABB);
        apply(0, 1, 0, 0, 1, 1, 1, 0, 2'b00, 1, 64'h103, RD32, 0,   5'd5, 1, 1, 64'h8899_AABB);
        // result mux: link beats load, plain ALU
        apply(0, 1, 0, 0, 1, 1, 1, 1, 2'b00, 0, 64'h1234, RD32, PC0, 5'd6, 1, 1, 64'h0040_0008);
        apply(0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 64'h1234, RD32, PC0, 5'd6, 1, 1, 64'h1234);
        // stall holds W and counter for 3 cycles, then flush under stall
        apply(0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 64'h77,  64'h0, 0,   5'd7, 1, 1, 64'h77);
        for (int i = 0; i < 3; i++)
            apply(0, 1, 1, 0, 1, 1, 0, 0, 2'b00, 0, 64'h99, 64'h0, 0, 5'd9, 1, 1, 64'h77);
        apply(0, 1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 64'h99,  64'h0, 0,   5'd9, 0, 0, 64'h0);
        // register-0 guard, then a not-valid write
        apply(0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 64'h55,  64'h0, 0,   5'd0, 1, 0, 64'h55);
        apply(0, 1, 0, 0, 0, 1, 0, 0, 2'b00, 0, 64'h66,  64'h0, 0,   5'd3, 0, 0, 64'h0);

        // 64-bit path
        apply(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 64'h0,   64'h0, 0,   5'd0, 0, 0, 64'h0);
        apply(1, 1, 0, 0, 1, 1, 1, 0, 2'b11, 1, 64'h0,   RD64,  0,   5'd4, 1, 1, RD64);
        apply(1, 1, 0, 0, 1, 1, 1, 0, 2'b00, 1, 64'h4,   RD64,  0,   5'd4, 1, 1, 64'hFFFF_FFFF_F0E0_D0C0);
        apply(1, 1, 0, 0, 1, 1, 1, 0, 2'b00, 0, 64'h3,   RD64,  0,   5'd4, 1, 1, 64'h0000_0000_B0A0_9080);
        apply(1, 1, 0, 0, 1, 1, 1, 0, 2'b10, 1, 64'h7,   RD64,  0,   5'd4, 1, 1, 64'hFFFF_FFFF_FFFF_FFF0);
        apply(1, 1, 0, 0, 1, 1, 1, 0, 2'b01, 0, 64'h5,   RD64,  0,   5'd4, 1, 1, 64'h0000_0000_0000_D0C0);
        // counter wrap: reset, then 16 valid loads bring a 4-bit counter back to 0
        apply(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 64'h0,   64'h0, 0,   5'd0, 0, 0, 64'h0);
        for (int i = 0; i < 16; i++)
            apply(1, 1, 0, 0, 1, 1, 1, 0, 2'b11, 0, 64'h8, RD64, 0, 5'd2, 1, 1, RD64);

        @(posedge clk);
        #3;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
